// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encodings,
// line idle level, default bit timing and the parity helper.
package uart_tx_fifo_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side byte port and line/status outputs of the UART transmitter.
// master = host logic, slave = transmitter.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] count;

    modport master (output din, din_valid, input din_ready, txd, busy, count);
    modport slave  (input din, din_valid, output din_ready, txd, busy, count);
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Circular byte buffer feeding the UART shifter. The count is one bit wider
// than the pointers so full and empty are distinguishable.
module uart_tx_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_push_data,
    input  logic                       i_push_valid,
    output logic                       o_push_ready,
    input  logic                       i_pop,
    output logic [7:0]                 o_pop_data,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Readiness comes from the registered count only, so a pop on the same
    // edge never opens room for a push into a full buffer.
    assign o_push_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = i_pop & (r_count != '0);
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: FIFO plus baud-timed frame FSM.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ST_IDLE   | line idle high, waiting for a queued byte
// ST_START  | start bit (low)
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | even parity bit (UART_TX_PARITY_EN only)
// ST_STOP   | STOP_BITS stop bits (high)
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    uart_tx_fifo_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]  w_count;
    logic [7:0]   w_pop_data;
    logic         w_push_ready;
    logic         w_pop;
    logic         w_baud_end;
    logic         w_last_stop;

    logic [2:0]   r_state;
    logic [15:0]  r_baud;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic         r_txd;
    logic         r_stop_cnt;
`ifdef UART_TX_PARITY_EN
    logic         r_parity;
`endif

    uart_tx_fifo_mem #(.DEPTH(FIFO_DEPTH)) u_mem (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push_data  (bus.din),
        .i_push_valid (bus.din_valid),
        .o_push_ready (w_push_ready),
        .i_pop        (w_pop),
        .o_pop_data   (w_pop_data),
        .o_count      (w_count)
    );

    assign w_baud_end  = (r_baud == 16'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_state == ST_STOP) && w_baud_end
                         && (r_stop_cnt == 1'(STOP_BITS - 1));
    // Popping on the final stop cycle keeps consecutive frames gapless.
    assign w_pop       = (w_count != '0) && ((r_state == ST_IDLE) || w_last_stop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= UART_IDLE_LEVEL;
            r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state <= ST_START;
            r_baud  <= '0;
            r_shift <= w_pop_data;
            r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= even_parity(w_pop_data);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd  <= UART_IDLE_LEVEL;
                    r_baud <= '0;
                end
                ST_START: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 16'd1;
                    if (w_baud_end) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 16'd1;
                    if (w_baud_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state    <= ST_STOP;
                            r_txd      <= UART_IDLE_LEVEL;
                            r_stop_cnt <= 1'b0;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 16'd1;
                    if (w_baud_end) begin
                        r_state    <= ST_STOP;
                        r_txd      <= UART_IDLE_LEVEL;
                        r_stop_cnt <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 16'd1;
                    if (w_last_stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_baud_end) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= UART_IDLE_LEVEL;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    assign bus.txd       = r_txd;
    assign bus.busy      = (r_state != ST_IDLE) | (w_count != '0);
    assign bus.count     = w_count;
    assign bus.din_ready = w_push_ready;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: every cycle the line, BUSY, COUNT and DIN_READY are
// compared to a queue-and-waveform model of the transmitter.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 10 + STOPB;
`else
    localparam int NBITS = 9 + STOPB;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (STOPB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    byte unsigned     q[$];
    int               frame_left = 0;
    logic [NBITS-1:0] bits = '1;
    bit               m_push = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NBITS-1:0] frame_bits(input byte unsigned b);
        logic [NBITS-1:0] r;
        r      = '1;
        r[0]   = 1'b0;
        r[8:1] = b;
`ifdef UART_TX_PARITY_EN
        r[9]   = ^b;
`endif
        return r;
    endfunction

    // One clock edge of the reference: a frame ends after FRAME cycles, the
    // next queued byte starts on that same edge, pushes land after the pop.
    task automatic model_step();
        bit           rdy;
        byte unsigned b;
        m_push = 1'b0;
        if (rst) begin
            q.delete();
            frame_left = 0;
        end else begin
            rdy = (q.size() != DEPTH);
            if (frame_left > 0) frame_left--;
            if (frame_left == 0 && q.size() != 0) begin
                b          = q.pop_front();
                bits       = frame_bits(b);
                frame_left = FRAME;
            end
            if (bus.din_valid && rdy) begin
                q.push_back(bus.din);
                m_push = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_txd;
        exp_txd = (frame_left > 0) ? bits[(FRAME - frame_left) / CPB] : 1'b1;
        check_eq("txd",       32'(bus.txd),       32'(exp_txd));
        check_eq("busy",      32'(bus.busy),      32'((frame_left > 0) || (q.size() != 0)));
        check_eq("count",     32'(bus.count),     32'(q.size()));
        check_eq("din_ready", 32'(bus.din_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic cycle(input bit r, input bit v, input byte unsigned d);
        rst           = r;
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    byte unsigned src[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                              8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

    initial begin
        int  idx;
        int  budget;
        bit  saw_full;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        idle(100);

        cycle(1'b0, 1'b1, 8'h55);
        idle(50);

        cycle(1'b0, 1'b1, 8'hA3);
        cycle(1'b0, 1'b1, 8'h0F);
        cycle(1'b0, 1'b1, 8'hFF);
        idle(3 * FRAME + 10);

        idx      = 0;
        budget   = 0;
        saw_full = 1'b0;
        while (idx < 10 && budget < 20 * FRAME) begin
            cycle(1'b0, 1'b1, src[idx]);
            if (q.size() == DEPTH) saw_full = 1'b1;
            if (m_push) idx++;
            budget++;
        end
        check_eq("src_drained", 32'(idx), 32'd10);
        check_eq("fifo_filled", 32'(saw_full), 32'd1);
        idle(10 * FRAME + 10);

        cycle(1'b0, 1'b1, 8'h3C);
        cycle(1'b0, 1'b1, 8'h81);
        cycle(1'b0, 1'b1, 8'h42);
        idle(15);
        cycle(1'b1, 1'b0, 8'h00);
        idle(5);
        cycle(1'b0, 1'b1, 8'h5A);
        idle(FRAME + 10);

        for (int i = 0; i < 800; i++)
            cycle(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
        idle(DEPTH * FRAME + FRAME + 10);

        cycle(1'b0, 1'b1, 8'h07);
        cycle(1'b0, 1'b1, 8'h03);
        idle(2 * FRAME + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
